// File: rtl/qfix_pkg.sv
// Shared fixed-point definitions for the sequential q-format datapath stages.
// Holds the common handshake FSM state and the iteration-count helper.
package qfix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } qfix_state_e;

  // Restoring divide steps needed for an N-bit sign-magnitude word with q fraction bits.
  function automatic int qfix_iter(input int n, input int q);
    return n - 1 + q;
  endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift in a numerator bit, trial-subtract the divisor,
// keep the difference when it is non-negative.
module qdiv_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_i,
  input  logic [N-2:0] dvs_i,
  input  logic         num_bit_i,
  output logic [N-1:0] rem_o,
  output logic         q_bit_o
);

  logic [N:0] shifted;
  logic [N:0] divisor_ext;
  logic [N:0] trial;

  // One spare bit so the shifted remainder is never truncated before the compare.
  assign shifted     = {rem_i, num_bit_i};
  assign divisor_ext = {2'b00, dvs_i};
  assign trial       = shifted - divisor_ext;
  assign q_bit_o     = (shifted >= divisor_ext);
  assign rem_o       = q_bit_o ? trial[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/qdiv_iter.sv
// Iterative sign-magnitude Q-format divider, one quotient bit per clock.
// Handshake: a pair is taken on an edge with in_valid && in_ready, a result is taken on an edge with out_valid && out_ready.
module qdiv_iter
  import qfix_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [N-1:0] quotient,
  output logic        overflow,
  output logic        div_by_zero,
  output qfix_state_e dbg_state
);

  localparam int ITER = qfix_iter(N, Q);
  localparam int W    = ITER;
  localparam int CW   = $clog2(ITER + 1);

  qfix_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  num_q, num_d;
  logic [W-2:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-2:0]  dvs_q, dvs_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  step_rem;
  logic          step_bit;
  logic [W-1:0]  quo_next;
  logic          final_ovf;
  logic [N-2:0]  final_mag;

  qdiv_step #(.N(N)) u_step (
    .rem_i     (rem_q),
    .dvs_i     (dvs_q),
    .num_bit_i (num_q[W-1]),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // The oldest quotient bit only matters for the saturation test, so it is not stored.
  assign quo_next  = {quo_q, step_bit};
  assign final_ovf = |quo_next[W-1:N-1];
  assign final_mag = final_ovf ? {(N-1){1'b1}} : quo_next[N-2:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    sign_d     = sign_q;
    quotient_d = quotient_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d  = {dividend[N-2:0], {Q{1'b0}}};
          dvs_d  = divisor[N-2:0];
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
          sign_d = dividend[N-1] ^ divisor[N-1];
          if (divisor[N-2:0] == '0) begin
            state_d    = DONE;
            quotient_d = {dividend[N-1] & (|dividend[N-2:0]), {(N-1){1'b1}}};
            ovf_d      = 1'b0;
            dbz_d      = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = quo_next[W-2:0];
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d    = DONE;
          quotient_d = {sign_q & (|final_mag), final_mag};
          ovf_d      = final_ovf;
          dbz_d      = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      sign_q     <= 1'b0;
      quotient_q <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      sign_q     <= sign_d;
      quotient_q <= quotient_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_qdiv_iter.sv
// Scoreboard bench for qdiv_iter: a driver pushes reference results on accept,
// a monitor pops and compares them whenever a result is presented.
module tb_qdiv_iter;
  import qfix_pkg::*;

  localparam int Q    = 15;
  localparam int N    = 32;
  localparam int ITER = N - 1 + Q;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [N-1:0] quotient;
  logic        overflow;
  logic        div_by_zero;
  qfix_state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {quotient, overflow, div_by_zero}, latency, drive time and hold length per accepted pair.
  logic [N+1:0] exp_q[$];
  int           lat_q[$];
  time          tdrv_q[$];
  int           hold_q[$];
  bit           mon_active;

  qdiv_iter #(.Q(Q), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: floor((|a| * 2^Q) / |b|) with saturation, signs combined without negative zero.
  function automatic logic [N+1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned num;
    longint unsigned den;
    longint unsigned q;
    logic [N-2:0]    mag;
    logic            sgn;
    logic            ovf;
    logic            dbz;
    num = longint'(a[N-2:0]) * (64'd1 << Q);
    den = longint'(b[N-2:0]);
    ovf = 1'b0;
    dbz = 1'b0;
    if (den == 0) begin
      dbz = 1'b1;
      mag = '1;
      sgn = a[N-1] && (a[N-2:0] != 0);
    end else begin
      q = num / den;
      if (q > ((64'd1 << (N - 1)) - 1)) begin
        ovf = 1'b1;
        mag = '1;
      end else begin
        mag = q[N-2:0];
      end
      sgn = (a[N-1] ^ b[N-1]) && (mag != 0);
    end
    return {sgn, mag, ovf, dbz};
  endfunction

  // Driver
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    exp_q.push_back(ref_div(a, b));
    // Counted from the driving negedge: accept edge, then ITER step edges for a real divide.
    lat_q.push_back((b[N-2:0] == 0) ? 1 : ITER + 1);
    tdrv_q.push_back($time);
    hold_q.push_back(hold);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
  endtask

  // Monitor / scoreboard
  initial begin
    logic [N+1:0] exp_v;
    int           exp_lat;
    time          t_drv;
    int           hold;
    exp_v      = '0;
    exp_lat    = 0;
    t_drv      = 0;
    hold       = 0;
    mon_active = 1'b0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        out_ready  = 1'b0;
      end else if (out_valid) begin
        if (!mon_active) begin
          mon_active = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(out_valid), 64'd0);
            hold = 0;
          end else begin
            exp_v   = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
            t_drv   = tdrv_q.pop_front();
            hold    = hold_q.pop_front();
            chk("latency", 64'(($time - t_drv) / 10), 64'(exp_lat));
            chk("result", 64'({quotient, overflow, div_by_zero}), 64'(exp_v));
          end
        end else begin
          chk("held_result", 64'({quotient, overflow, div_by_zero}), 64'(exp_v));
          chk("held_in_ready", 64'(in_ready), 64'd0);
        end
        if (hold > 0) begin
          hold--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        if (mon_active) begin
          chk("return_idle", 64'(in_ready), 64'd1);
          mon_active = 1'b0;
        end
        out_ready = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           waited;
    bit           saw_valid;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({quotient, overflow, div_by_zero}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));

    send(32'h0001_8000, 32'h0001_0000, 0);
    send(32'h8001_8000, 32'h0001_0000, 0);
    send(32'h8001_8000, 32'h8001_0000, 1);
    send(32'h8000_0000, 32'h0000_8000, 0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 0);
    send(32'h8001_0000, 32'h8000_0000, 0);
    send(32'h0000_0000, 32'h8000_0000, 0);
    send(32'h0003_0000, 32'h0000_8000, 10);

    for (int i = 0; i < 40; i++) begin
      a = {1'($urandom()), 31'($urandom() >> $urandom_range(1, 31))};
      if ($urandom_range(0, 9) == 0) b = {1'($urandom()), 31'd0};
      else b = {1'($urandom()), 31'($urandom() >> $urandom_range(1, 31))};
      if (b[N-2:0] == 0 && $urandom_range(0, 1) == 0) b[0] = 1'b1;
      send(a, b, $urandom_range(0, 3));
    end

    // Reset in the middle of a divide discards it.
    send(32'h0001_8000, 32'h0001_0000, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    tdrv_q.delete();
    hold_q.delete();
    @(negedge clk);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    chk("midrst_outputs", 64'({out_valid, quotient, overflow, div_by_zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_result", 64'(saw_valid), 64'd0);
    send(32'h0000_8000, 32'h0000_8000, 0);

    waited = 0;
    while ((exp_q.size() != 0 || mon_active) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
